// File: rtl/adc_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_cap_pkg
// Description : Shared types and constants for the ADC capture controller:
//               FSM state encoding, formatter channel modes, timing defaults.
// Revision    : 1.0  initial release
// ============================================================================
package adc_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [1:0] CH_TEST = 2'b00;
  localparam logic [1:0] CH_A    = 2'b01;
  localparam logic [1:0] CH_B    = 2'b10;
  localparam logic [1:0] CH_DUAL = 2'b11;

  localparam int ARM_CYCLES_DFLT   = 2;
  localparam int DRAIN_CYCLES_DFLT = 3;

  // Dual interleave emits A/B pairs, so an odd frame length would split a pair.
  function automatic logic [15:0] eff_len(input logic [1:0] mode, input logic [15:0] len);
    return (mode == CH_DUAL) ? {len[15:1], 1'b0} : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Frame scheduler for the ADC sample formatter. Sequences the
//               formatter enable/channel select, throttles on FIFO
//               back-pressure and writes exactly frame_len words per frame
//               with SOF/EOF markers into the TX FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int ARM_CYCLES   = ARM_CYCLES_DFLT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [1:0]  cfg_ch_sel,
  input  logic [15:0] cfg_frame_len,
  input  logic        cfg_continuous,
  input  logic [15:0] cfg_gap,
  output logic        ad_data_en,
  output logic [1:0]  ch_sel,
  input  logic [15:0] ad_out,
  input  logic        ad_out_valid,
  output logic [15:0] fifo_wdata,
  output logic        fifo_wr,
  output logic        fifo_sof,
  output logic        fifo_eof,
  input  logic        fifo_almost_full,
  output logic        busy,
  output logic        cfg_err,
  output logic [15:0] frame_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tmr;
  logic [15:0] w_tmr_nxt;
  logic [15:0] r_wcnt;
  logic [15:0] w_wcnt_nxt;
  logic [15:0] r_len;
  logic [1:0]  r_mode;
  logic        r_cont;
  logic [15:0] r_gap;
  logic        r_stop_pend;
  logic        r_en;
  logic [1:0]  r_ch_sel;
  logic [15:0] r_wdata;
  logic        r_wr;
  logic        r_sof;
  logic        r_eof;
  logic        r_err;
  logic [15:0] r_frame_cnt;

  logic [15:0] w_eff_len;
  logic        w_wr;
  logic        w_done;
  logic        w_en_nxt;

  assign w_eff_len = eff_len(cfg_ch_sel, cfg_frame_len);
  assign w_wr      = (r_state == ST_RUN) && ad_out_valid && (r_wcnt < r_len);
  assign w_done    = (r_state == ST_RUN) && (r_wcnt == r_len);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, shared ARM/DRAIN/GAP down-counter, word count and next enable.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cfg_start && (w_eff_len != 16'd0)) w_state_nxt = ST_ARM;
      ST_ARM:   if (r_tmr == 16'd0) w_state_nxt = ST_RUN;
      ST_RUN:   if (r_wcnt == r_len) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (r_tmr == 16'd0) begin
          if (r_cont && !r_stop_pend && !cfg_stop)
            w_state_nxt = (r_gap == 16'd0) ? ST_ARM : ST_GAP;
          else
            w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cfg_stop)             w_state_nxt = ST_IDLE;
        else if (r_tmr == 16'd0)  w_state_nxt = ST_ARM;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase

    w_tmr_nxt = (r_tmr != 16'd0) ? (r_tmr - 16'd1) : 16'd0;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_ARM:   w_tmr_nxt = 16'(ARM_CYCLES - 1);
        ST_DRAIN: w_tmr_nxt = 16'(DRAIN_CYCLES - 1);
        ST_GAP:   w_tmr_nxt = r_gap - 16'd1;
        default:  w_tmr_nxt = 16'd0;
      endcase
    end

    w_wcnt_nxt = (r_state == ST_ARM) ? 16'd0 : (r_wcnt + {15'd0, w_wr});
    w_en_nxt   = (w_state_nxt == ST_RUN) && !fifo_almost_full && (w_wcnt_nxt < r_len);
  end

  // Command latch, formatter control, FIFO write stage and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr       <= 16'd0;
      r_wcnt      <= 16'd0;
      r_len       <= 16'd0;
      r_mode      <= CH_TEST;
      r_cont      <= 1'b0;
      r_gap       <= 16'd0;
      r_stop_pend <= 1'b0;
      r_en        <= 1'b0;
      r_ch_sel    <= CH_TEST;
      r_wdata     <= 16'd0;
      r_wr        <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_tmr  <= w_tmr_nxt;
      r_wcnt <= w_wcnt_nxt;
      r_en   <= w_en_nxt;
      r_err  <= (r_state == ST_IDLE) && cfg_start && (w_eff_len == 16'd0);

      if ((r_state == ST_IDLE) && cfg_start) begin
        r_mode <= cfg_ch_sel;
        r_len  <= w_eff_len;
        r_cont <= cfg_continuous;
        r_gap  <= cfg_gap;
      end

      // Stop is remembered until the frame in progress has drained.
      if ((r_state == ST_ARM) || (r_state == ST_RUN) || (r_state == ST_DRAIN))
        r_stop_pend <= r_stop_pend | cfg_stop;
      else
        r_stop_pend <= 1'b0;

      // Channel select only moves on ARM entry, while enable is guaranteed low.
      if ((w_state_nxt == ST_ARM) && (r_state != ST_ARM))
        r_ch_sel <= (r_state == ST_IDLE) ? cfg_ch_sel : r_mode;

      r_wr  <= w_wr;
      r_sof <= w_wr && (r_wcnt == 16'd0);
      r_eof <= w_wr && (r_wcnt == (r_len - 16'd1));
      if (w_wr) r_wdata <= ad_out;

      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign ad_data_en = r_en;
  assign ch_sel     = r_ch_sel;
  assign fifo_wdata = r_wdata;
  assign fifo_wr    = r_wr;
  assign fifo_sof   = r_sof;
  assign fifo_eof   = r_eof;
  assign busy       = (r_state != ST_IDLE);
  assign cfg_err    = r_err;
  assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_ctrl
// Description : Directed self-checking bench for adc_capture_ctrl with a
//               behavioural formatter and a FIFO write monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_capture_ctrl;
  import adc_cap_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cfg_start, cfg_stop, cfg_continuous;
  logic [1:0]  cfg_ch_sel;
  logic [15:0] cfg_frame_len, cfg_gap;
  logic        ad_data_en;
  logic [1:0]  ch_sel;
  logic [15:0] ad_out;
  logic        ad_out_valid;
  logic [15:0] fifo_wdata;
  logic        fifo_wr, fifo_sof, fifo_eof, fifo_almost_full;
  logic        busy, cfg_err;
  logic [15:0] frame_cnt;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  adc_capture_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_ch_sel(cfg_ch_sel), .cfg_frame_len(cfg_frame_len),
    .cfg_continuous(cfg_continuous), .cfg_gap(cfg_gap),
    .ad_data_en(ad_data_en), .ch_sel(ch_sel), .ad_out(ad_out),
    .ad_out_valid(ad_out_valid), .fifo_wdata(fifo_wdata), .fifo_wr(fifo_wr),
    .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
    .fifo_almost_full(fifo_almost_full), .busy(busy), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter, read only on negedges.
  always @(posedge clk) cyc <= cyc + 1;

  // Formatter: 1-cycle latency in single modes, ramp restarts on pause in
  // test mode, dual mode emits an A/B pair per 3 enabled cycles.
  logic        fmt_clr;
  logic [15:0] f_n, f_ramp;
  logic [1:0]  f_ph;
  always @(posedge clk) begin
    if (fmt_clr) begin
      ad_out_valid <= 1'b0; ad_out <= 16'd0; f_n <= 16'd0; f_ramp <= 16'd0; f_ph <= 2'd0;
    end else begin
      ad_out_valid <= 1'b0;
      if (ad_data_en) begin
        case (ch_sel)
          CH_TEST: begin ad_out_valid <= 1'b1; ad_out <= f_ramp; f_ramp <= f_ramp + 16'd1; end
          CH_A:    begin ad_out_valid <= 1'b1; ad_out <= 16'hA000 + f_n; f_n <= f_n + 16'd1; end
          CH_B:    begin ad_out_valid <= 1'b1; ad_out <= 16'hB000 + f_n; f_n <= f_n + 16'd1; end
          default: begin
            if (f_ph == 2'd1) begin
              ad_out_valid <= 1'b1; ad_out <= 16'hA000 + f_n;
            end else if (f_ph == 2'd2) begin
              ad_out_valid <= 1'b1; ad_out <= 16'hB000 + f_n; f_n <= f_n + 16'd1;
            end
            f_ph <= (f_ph == 2'd2) ? 2'd0 : f_ph + 2'd1;
          end
        endcase
      end else begin
        f_ramp <= 16'd0;
        f_ph   <= 2'd0;
      end
    end
  end

  // FIFO write monitor.
  logic [15:0] m_data [256];
  logic        m_sof  [256];
  logic        m_eof  [256];
  int          m_cyc  [256];
  int          mon_n = 0;
  always @(negedge clk) begin
    if (fifo_wr === 1'b1 && mon_n < 256) begin
      m_data[mon_n] <= fifo_wdata;
      m_sof[mon_n]  <= fifo_sof;
      m_eof[mon_n]  <= fifo_eof;
      m_cyc[mon_n]  <= cyc;
      mon_n         <= mon_n + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fmt_clr = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; fifo_almost_full = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; fmt_clr = 1'b0;
    @(negedge clk);
  endtask

  // Pulses cfg_start in cycle t; returns at the negedge of t+1.
  task automatic start_cmd(input logic [1:0] m, input logic [15:0] l, input logic c,
                           input logic [15:0] g, output int t);
    cfg_ch_sel = m; cfg_frame_len = l; cfg_continuous = c; cfg_gap = g;
    cfg_start = 1'b1; t = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int b);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    b = cyc;
    if (busy !== 1'b0) begin
      vec++; err++;
      $display("FAIL wait_idle: busy=%b still after %0d cycles, want 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({ad_data_en, ch_sel, fifo_wr, fifo_wdata, fifo_sof, fifo_eof, busy, cfg_err, frame_cnt} !== 40'd0) begin
      err++; $display("FAIL reset_state: got en=%b ch=%b wr=%b wd=%h sof=%b eof=%b busy=%b err=%b fc=%0d, want all 0",
                      ad_data_en, ch_sel, fifo_wr, fifo_wdata, fifo_sof, fifo_eof, busy, cfg_err, frame_cnt);
    end
  endtask

  task automatic test_oneshot_a();
    int t, s, b, bad;
    do_reset(); s = mon_n;
    start_cmd(CH_A, 16'd8, 1'b0, 16'd0, t);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL oneshot_busy_t1: got %b want 1", busy); end
    @(negedge clk);
    vec++; if ({ad_data_en, ch_sel} !== 3'b001) begin err++; $display("FAIL oneshot_arm: got en=%b ch=%b want en=0 ch=01", ad_data_en, ch_sel); end
    @(negedge clk);
    vec++; if (ad_data_en !== 1'b1) begin err++; $display("FAIL oneshot_en_t3: got %b want 1", ad_data_en); end
    wait_idle(60, b);
    vec++; if (b !== t + 16) begin err++; $display("FAIL oneshot_idle_time: got t+%0d want t+16", b - t); end
    vec++; if (mon_n - s !== 8) begin err++; $display("FAIL oneshot_count: got %0d want 8", mon_n - s); end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (m_data[s+i] !== 16'hA000 + 16'(i) || m_sof[s+i] !== (i == 0) || m_eof[s+i] !== (i == 7)) bad++;
    vec++; if (bad !== 0) begin err++; $display("FAIL oneshot_words: got %0d bad words want 0", bad); end
    vec++; if (m_cyc[s] !== t + 5 || m_cyc[s+7] !== t + 12) begin
      err++; $display("FAIL oneshot_wr_timing: got first t+%0d last t+%0d want t+5 t+12", m_cyc[s] - t, m_cyc[s+7] - t);
    end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL oneshot_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_dual();
    int t, s, b, bad;
    logic [15:0] exp;
    do_reset(); s = mon_n;
    start_cmd(CH_DUAL, 16'd7, 1'b0, 16'd0, t);
    wait_idle(60, b);
    vec++; if (mon_n - s !== 6) begin err++; $display("FAIL dual_count: got %0d want 6", mon_n - s); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      exp = ((i % 2) != 0 ? 16'hB000 : 16'hA000) + 16'(i / 2);
      if (m_data[s+i] !== exp || m_sof[s+i] !== (i == 0) || m_eof[s+i] !== (i == 5)) bad++;
    end
    vec++; if (bad !== 0) begin err++; $display("FAIL dual_words: got %0d bad words want 0", bad); end
    vec++; if ({ch_sel, frame_cnt} !== {2'b11, 16'd1}) begin
      err++; $display("FAIL dual_status: got ch=%b fc=%0d want ch=11 fc=1", ch_sel, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int t, s, b, p, k, lowbad, gapw, nsof, neof;
    do_reset(); s = mon_n;
    start_cmd(CH_TEST, 16'd20, 1'b0, 16'd0, t);
    k = 0;
    while (mon_n - s < 6 && k < 40) begin @(negedge clk); k++; end
    vec++; if (mon_n - s < 6) begin err++; $display("FAIL bp_first_words: got %0d want >=6", mon_n - s); end
    fifo_almost_full = 1'b1; p = cyc; lowbad = 0;
    for (int i = 1; i <= 5; i++) begin @(negedge clk); if (ad_data_en !== 1'b0) lowbad++; end
    fifo_almost_full = 1'b0;
    vec++; if (lowbad !== 0) begin err++; $display("FAIL bp_enable_low: got %0d high cycles want 0", lowbad); end
    @(negedge clk);
    vec++; if (ad_data_en !== 1'b1) begin err++; $display("FAIL bp_resume: got %b want 1", ad_data_en); end
    wait_idle(120, b);
    gapw = 0; nsof = 0; neof = 0;
    for (int i = s; i < mon_n; i++) begin
      if (m_cyc[i] >= p + 3 && m_cyc[i] <= p + 7) gapw++;
      if (m_sof[i] === 1'b1) nsof++;
      if (m_eof[i] === 1'b1) neof++;
    end
    vec++; if (mon_n - s !== 20) begin err++; $display("FAIL bp_count: got %0d want 20", mon_n - s); end
    vec++; if (gapw !== 0) begin err++; $display("FAIL bp_paused_writes: got %0d want 0", gapw); end
    vec++; if (nsof !== 1 || neof !== 1 || m_eof[s+19] !== 1'b1) begin
      err++; $display("FAIL bp_markers: got sof=%0d eof=%0d want 1 1 with eof last", nsof, neof);
    end
  endtask

  task automatic test_continuous();
    int t, s, b, k, rises, bad;
    int r [4];
    logic pe, stopped;
    do_reset(); s = mon_n;
    start_cmd(CH_B, 16'd4, 1'b1, 16'd10, t);
    rises = 0; pe = 1'b0; stopped = 1'b0; k = 0;
    while (busy === 1'b1 && k < 300) begin
      if (ad_data_en === 1'b1 && pe !== 1'b1) begin
        if (rises < 4) r[rises] = cyc;
        rises++;
      end
      pe = ad_data_en;
      if (rises == 3 && !stopped) begin cfg_stop = 1'b1; stopped = 1'b1; end
      else cfg_stop = 1'b0;
      @(negedge clk); k++;
    end
    cfg_stop = 1'b0; b = cyc;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL cont_timeout: busy=%b want 0", busy); end
    vec++; if (rises !== 3) begin err++; $display("FAIL cont_frames: got %0d enable bursts want 3", rises); end
    vec++; if (mon_n - s !== 12) begin err++; $display("FAIL cont_count: got %0d want 12", mon_n - s); end
    vec++; if (r[0] !== t + 3) begin err++; $display("FAIL cont_first_en: got t+%0d want t+3", r[0] - t); end
    vec++; if (r[1] - m_cyc[s+3] !== 16 || r[2] - m_cyc[s+7] !== 16) begin
      err++; $display("FAIL cont_gap: got %0d %0d cycles eof->enable want 16 16", r[1] - m_cyc[s+3], r[2] - m_cyc[s+7]);
    end
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (m_data[s+i] !== 16'hB000 + 16'(5 * (i / 4) + (i % 4)) || m_eof[s+i] !== ((i % 4) == 3)) bad++;
    vec++; if (bad !== 0) begin err++; $display("FAIL cont_words: got %0d bad words want 0", bad); end
    vec++; if (b !== m_cyc[s+11] + 4) begin err++; $display("FAIL cont_idle_time: got eof+%0d want eof+4", b - m_cyc[s+11]); end
    vec++; if ({ch_sel, frame_cnt} !== {2'b10, 16'd3}) begin
      err++; $display("FAIL cont_status: got ch=%b fc=%0d want ch=10 fc=3", ch_sel, frame_cnt);
    end
  endtask

  task automatic test_len_zero();
    int t, s, b, bad;
    do_reset(); s = mon_n;
    start_cmd(CH_A, 16'd0, 1'b0, 16'd0, t);
    vec++; if ({cfg_err, busy} !== 2'b10) begin err++; $display("FAIL zero_err_pulse: got err=%b busy=%b want 1 0", cfg_err, busy); end
    @(negedge clk);
    vec++; if (cfg_err !== 1'b0) begin err++; $display("FAIL zero_err_width: got %b want 0", cfg_err); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (ad_data_en !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    vec++; if (bad !== 0) begin err++; $display("FAIL zero_no_activity: got %0d active cycles want 0", bad); end
    start_cmd(CH_A, 16'd2, 1'b0, 16'd0, t);
    vec++; if ({cfg_err, busy} !== 2'b01) begin err++; $display("FAIL zero_retry_start: got err=%b busy=%b want 0 1", cfg_err, busy); end
    wait_idle(40, b);
    vec++; if (mon_n - s !== 2 || m_data[s] !== 16'hA000 || m_data[s+1] !== 16'hA001 ||
               m_sof[s] !== 1'b1 || m_eof[s+1] !== 1'b1 || frame_cnt !== 16'd1) begin
      err++; $display("FAIL zero_retry_frame: got n=%0d d0=%h d1=%h fc=%0d want n=2 a000 a001 fc=1",
                      mon_n - s, m_data[s], m_data[s+1], frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int t, s0, s, b, k, n, neof;
    do_reset(); s0 = mon_n;
    start_cmd(CH_A, 16'd8, 1'b0, 16'd0, t);
    n = 0; k = 0;
    while (n < 3 && k < 40) begin @(negedge clk); k++; if (fifo_wr === 1'b1) n++; end
    vec++; if (n !== 3) begin err++; $display("FAIL rst_mid_reach: got %0d writes want 3", n); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if ({ad_data_en, ch_sel, fifo_wr, fifo_wdata, fifo_sof, fifo_eof, busy, cfg_err, frame_cnt} !== 40'd0) begin
      err++; $display("FAIL rst_mid_outputs: got en=%b ch=%b wr=%b wd=%h eof=%b busy=%b fc=%0d want all 0",
                      ad_data_en, ch_sel, fifo_wr, fifo_wdata, fifo_eof, busy, frame_cnt);
    end
    repeat (3) @(negedge clk);
    neof = 0;
    for (int i = s0; i < mon_n; i++) if (m_eof[i] === 1'b1) neof++;
    vec++; if (mon_n - s0 !== 3 || neof !== 0) begin
      err++; $display("FAIL rst_mid_abort: got %0d writes %0d eof want 3 writes 0 eof", mon_n - s0, neof);
    end
    s = mon_n;
    start_cmd(CH_A, 16'd8, 1'b0, 16'd0, t);
    wait_idle(60, b);
    vec++; if (mon_n - s !== 8 || m_sof[s] !== 1'b1 || m_eof[s+7] !== 1'b1 || frame_cnt !== 16'd1) begin
      err++; $display("FAIL rst_mid_restart: got n=%0d sof=%b eof=%b fc=%0d want 8 1 1 1",
                      mon_n - s, m_sof[s], m_eof[s+7], frame_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; fmt_clr = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_ch_sel = 2'b00; cfg_frame_len = 16'd0; cfg_continuous = 1'b0; cfg_gap = 16'd0;
    fifo_almost_full = 1'b0;
    test_reset();
    test_oneshot_a();
    test_dual();
    test_backpressure();
    test_continuous();
    test_len_zero();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
`default_nettype wire
